// File: rtl/reg_file_mp_if.sv
// Register-file bus: decode-side read addresses, writeback-side write ports,
// clear request and debug read.
//
// Handshake: there is no valid/ready pair. Each i_wr_en bit is a single-cycle
// write strobe that is consumed at the rising edge where it is seen. While
// o_busy is 1 the array is being cleared. Strobes in that window are dropped,
// not queued, so the core must stall on o_busy. Reads are combinational and
// always valid: they read 0 while o_busy is 1.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] i_rd_addr;
  logic [NUM_RD*DATA_W-1:0] o_rd_dat;
  logic [1:0]               i_wr_en;
  logic [2*ADDR_W-1:0]      i_wr_addr;
  logic [2*DATA_W-1:0]      i_wr_dat;
  logic                     i_clr_req;
  logic                     o_busy;
  logic [ADDR_W-1:0]        i_dbg_addr;
  logic [DATA_W-1:0]        o_dbg_dat;

  // Core side: drives addresses, write strobes and clear request.
  modport master (
    output i_rd_addr, i_wr_en, i_wr_addr, i_wr_dat, i_clr_req, i_dbg_addr,
    input  o_rd_dat, o_busy, o_dbg_dat
  );

  // Register-file side.
  modport slave (
    input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_dat, i_clr_req, i_dbg_addr,
    output o_rd_dat, o_busy, o_dbg_dat
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NUM_RD combinational read ports and two
// write ports (port 1 wins on an address collision). Entry 0 can optionally
// be hardwired to zero. Same-cycle write-to-read forwarding is optional. A
// clear sequencer zeroes the whole array after reset or on request. The FSM
// state is exported on o_fsm_state (1 = clearing).
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_mp_if.slave  io_rf,
  output logic          o_fsm_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic [1:0]        w_commit;
  logic [ADDR_W-1:0] w_wr_addr [2];
  logic [DATA_W-1:0] w_wr_dat  [2];
  logic [NUM_RD*DATA_W-1:0] w_rd_dat;
  logic [DATA_W-1:0] w_dbg_dat;

  // Clear sequencer. Reset and a clear request both restart the sweep at
  // entry 0. A request that arrives while a sweep is running is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == LAST_PTR) r_state <= S_IDLE;
        end
        default: begin
          if (io_rf.i_clr_req) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
          end
        end
      endcase
    end
  end

  assign w_busy      = (r_state == S_CLEAR);
  assign o_fsm_state = r_state;
  assign io_rf.o_busy = w_busy;

  // Unpack the write ports and decide which ones actually commit this cycle.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_wr_addr[p] = io_rf.i_wr_addr[p*ADDR_W +: ADDR_W];
      w_wr_dat[p]  = io_rf.i_wr_dat[p*DATA_W +: DATA_W];
      w_commit[p]  = io_rf.i_wr_en[p] && !w_busy &&
                     !((ZERO_REG != 0) && (w_wr_addr[p] == '0));
    end
  end

  // Storage has no reset. While clearing, only the sweep writes. Otherwise
  // port 1 is written after port 0, so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_clr_ptr] <= '0;
    end else begin
      if (w_commit[0]) r_mem[w_wr_addr[0]] <= w_wr_dat[0];
      if (w_commit[1]) r_mem[w_wr_addr[1]] <= w_wr_dat[1];
    end
  end

  // One read port. Forced to zero while busy or for a hardwired x0. When
  // forwarding is enabled, a committing write overrides the array value, and
  // port 1 takes priority over port 0.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = r_mem[a];
    if (BYPASS != 0) begin
      if (w_commit[1] && (w_wr_addr[1] == a))      v = w_wr_dat[1];
      else if (w_commit[0] && (w_wr_addr[0] == a)) v = w_wr_dat[0];
    end
    if (w_busy || ((ZERO_REG != 0) && (a == '0))) v = '0;
    return v;
  endfunction

  // Combinational read ports.
  always_comb begin
    w_rd_dat = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_rd_dat[k*DATA_W +: DATA_W] = read_port(io_rf.i_rd_addr[k*ADDR_W +: ADDR_W]);
    end
  end

  assign io_rf.o_rd_dat = w_rd_dat;

  // Debug read: same zero masking as the read ports, never forwarded.
  always_comb begin
    w_dbg_dat = r_mem[io_rf.i_dbg_addr];
    if (w_busy || ((ZERO_REG != 0) && (io_rf.i_dbg_addr == '0))) w_dbg_dat = '0;
  end

  assign io_rf.o_dbg_dat = w_dbg_dat;

endmodule
